// File: rtl/shift_seq_pkg.sv
// Shared types and helpers for the shift-register load sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } seq_state_t;

  localparam int DATA_W_DEF = 4;

  // Width of a down-counter that must hold shift_cycles-2; never narrower than 1 bit.
  function automatic int cnt_w(input int shift_cycles);
    if (shift_cycles <= 2) return 1;
    else return $clog2(shift_cycles - 1);
  endfunction

endpackage

// File: rtl/shift_seq_fifo.sv
// Synchronous FIFO feeding the sequencer; a push into a full FIFO is dropped even when a pop
// happens on the same edge (no write bypass).
module shift_seq_fifo
  import shift_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [DATA_W-1:0]          i_wdata,
  input  logic                       i_pop,
  output logic [DATA_W-1:0]          o_rdata,
  output logic [$clog2(DEPTH+1)-1:0] o_level,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/shift_load_sequencer.sv
// Buffers source words and issues one load strobe per word every SHIFT_CYCLES cycles.
// Optional statistics counters are built when SHIFT_SEQ_STATS_EN is defined.
module shift_load_sequencer
  import shift_seq_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int DEPTH        = 4,
  parameter int SHIFT_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       s_valid,
  input  logic [DATA_W-1:0]          s_data,
  output logic                       s_ready,
  output logic                       load,
  output logic [DATA_W-1:0]          parallel_data_in,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                       underrun
`ifdef SHIFT_SEQ_STATS_EN
  ,
  output logic [15:0]                words_loaded,
  output logic [15:0]                underrun_cnt
`endif
);

  localparam int CW = cnt_w(SHIFT_CYCLES);
  localparam logic [CW-1:0] CNT_INIT = CW'(SHIFT_CYCLES - 2);

  seq_state_t        r_state;
  logic [CW-1:0]     r_cnt;
  logic              r_load;
  logic [DATA_W-1:0] r_pdi;
  logic              r_underrun;

  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_rdata;
  logic              w_push;
  logic              w_window_end;
  logic              w_start;
  logic              w_underrun_set;

  assign s_ready        = ~w_full & reset;
  assign w_push         = s_valid & s_ready;
  assign w_window_end   = (r_state == SHIFT) && (r_cnt == '0);
  assign w_start        = en && !w_empty && ((r_state == IDLE) || w_window_end);
  assign w_underrun_set = w_window_end && en && w_empty;

  shift_seq_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_wdata (s_data),
    .i_pop   (w_start),
    .o_rdata (w_rdata),
    .o_level (fifo_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // The popped word is captured on the same edge that enters LOAD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_load     <= 1'b0;
      r_pdi      <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_load     <= 1'b0;
      r_underrun <= 1'b0;
      if (w_start) begin
        r_state <= LOAD;
        r_load  <= 1'b1;
        r_pdi   <= w_rdata;
      end else begin
        case (r_state)
          LOAD: begin
            r_state <= SHIFT;
            r_cnt   <= CNT_INIT;
          end
          SHIFT: begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - CW'(1);
            end else begin
              r_state    <= IDLE;
              r_underrun <= w_underrun_set;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign load             = r_load;
  assign parallel_data_in = r_pdi;
  assign underrun         = r_underrun;
  assign busy             = (r_state != IDLE);

`ifdef SHIFT_SEQ_STATS_EN
  logic [15:0] r_words_loaded;
  logic [15:0] r_underrun_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_words_loaded <= '0;
      r_underrun_cnt <= '0;
    end else begin
      if (w_start && (r_words_loaded != 16'hFFFF))
        r_words_loaded <= r_words_loaded + 16'd1;
      if (w_underrun_set && (r_underrun_cnt != 16'hFFFF))
        r_underrun_cnt <= r_underrun_cnt + 16'd1;
    end
  end

  assign words_loaded = r_words_loaded;
  assign underrun_cnt = r_underrun_cnt;
`endif

endmodule
